slave_line_receiver: RTL and testbench

SLAVE_LINE_RECEIVER -- requirements
Module: slave_line_receiver

---
 rtl/slave_line_receiver.sv | 223 ++++++++++++++++++++++
 tb/tb_slave_line_receiver.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/slave_line_receiver.sv
// Three-wire line receiver: filters the low-power line code, runs the
// STOP / HS request / HS prepare / HS receive sequence and decodes
// high-speed wire-state transitions into 3-bit symbols.
module slave_line_receiver #(
    parameter int LP_FILTER   = 2,
    parameter int HS_PREP_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [7:0] C,
    input  logic       RxEn,
    output logic [2:0] LpState,
    output logic       StopState,
    output logic       HsActive,
    output logic [2:0] SymOut,
    output logic       SymValid,
    output logic       ErrSeq,
    output logic       ErrSym
);
    localparam int FW = $clog2(LP_FILTER + 1);
    localparam int PW = $clog2(HS_PREP_MAX + 2);
    localparam logic [FW-1:0] FLT_TARGET = FW'(LP_FILTER);
    localparam logic [PW-1:0] PREP_LIMIT = PW'(HS_PREP_MAX);

    typedef enum logic [1:0] {
        ST_STOP,
        ST_HS_RQST,
        ST_HS_PREP,
        ST_HS_RX
    } state_t;

    state_t          state_reg;
    logic [2:0]      lp_last_reg;
    logic [FW-1:0]   flt_cnt_reg;
    logic [PW-1:0]   prep_cnt_reg;
    logic [1:0]      prev_pair_reg;
    logic            prev_pos_reg;
    logic [2:0]      lp_state_reg;
    logic            stop_state_reg;
    logic            hs_active_reg;
    logic [2:0]      sym_out_reg;
    logic            sym_valid_reg;
    logic            err_seq_reg;
    logic            err_sym_reg;

    // Index 0 is wire A so LP code bit 2 is A, matching {A,B,C}
    logic [7:0] level [3];
    logic [2:0] lp_raw;
    logic [2:0] is_l;
    logic [2:0] is_m;
    logic [2:0] is_h;

    assign level[0] = A;
    assign level[1] = B;
    assign level[2] = C;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_wire
            assign lp_raw[2-gi] = (level[gi] >= 8'd70) && (level[gi] != 8'd255);
            assign is_l[gi]     = (level[gi] == 8'd0);
            assign is_m[gi]     = (level[gi] == 8'd20);
            assign is_h[gi]     = (level[gi] == 8'd40);
        end
    endgenerate

    // Wire-state decode: pair index (x=0,y=1,z=2) and sign (1 = positive)
    logic       ws_valid;
    logic [1:0] ws_pair;
    logic       ws_pos;

    // Map the three wire classes onto one of the six legal wire states
    always_comb begin
        ws_valid = 1'b1;
        ws_pair  = 2'd0;
        ws_pos   = 1'b0;
        if (is_h[0] && is_l[1] && is_m[2]) begin
            ws_pair = 2'd0; ws_pos = 1'b1;
        end else if (is_l[0] && is_h[1] && is_m[2]) begin
            ws_pair = 2'd0; ws_pos = 1'b0;
        end else if (is_m[0] && is_h[1] && is_l[2]) begin
            ws_pair = 2'd1; ws_pos = 1'b1;
        end else if (is_m[0] && is_l[1] && is_h[2]) begin
            ws_pair = 2'd1; ws_pos = 1'b0;
        end else if (is_l[0] && is_m[1] && is_h[2]) begin
            ws_pair = 2'd2; ws_pos = 1'b1;
        end else if (is_h[0] && is_m[1] && is_l[2]) begin
            ws_pair = 2'd2; ws_pos = 1'b0;
        end else begin
            ws_valid = 1'b0;
        end
    end

    // LP filter: accept a code once, on the cycle its run length reaches the target
    logic          same_code;
    logic [FW-1:0] flt_cnt_next;
    logic          lp_accept;

    always_comb begin
        same_code = (lp_raw == lp_last_reg);
        if (!same_code) begin
            flt_cnt_next = FW'(1);
        end else if (flt_cnt_reg == FLT_TARGET) begin
            flt_cnt_next = flt_cnt_reg;
        end else begin
            flt_cnt_next = flt_cnt_reg + FW'(1);
        end
        lp_accept = (flt_cnt_next == FLT_TARGET) &&
                    (!same_code || (flt_cnt_reg != FLT_TARGET));
    end

    // Symbol computed from the previous and current wire state
    logic [1:0] rot_pair;
    logic       same_state;
    logic [2:0] sym;

    always_comb begin
        rot_pair   = (prev_pair_reg == 2'd2) ? 2'd0 : prev_pair_reg + 2'd1;
        same_state = ws_valid && (ws_pair == prev_pair_reg) && (ws_pos == prev_pos_reg);
        if (ws_pair == prev_pair_reg) begin
            sym = 3'b100;
        end else begin
            sym = {1'b0, (ws_pair == rot_pair), (ws_pos != prev_pos_reg)};
        end
    end

    // Receiver FSM with registered status, symbol and error outputs
    always_ff @(posedge clk) begin
        if (!rst_n || !RxEn) begin
            state_reg      <= ST_STOP;
            lp_last_reg    <= 3'b000;
            flt_cnt_reg    <= '0;
            prep_cnt_reg   <= '0;
            prev_pair_reg  <= 2'd0;
            prev_pos_reg   <= 1'b0;
            lp_state_reg   <= 3'b000;
            stop_state_reg <= 1'b1;
            hs_active_reg  <= 1'b0;
            sym_out_reg    <= 3'b000;
            sym_valid_reg  <= 1'b0;
            err_seq_reg    <= 1'b0;
            err_sym_reg    <= 1'b0;
        end else begin
            lp_last_reg   <= lp_raw;
            flt_cnt_reg   <= flt_cnt_next;
            sym_valid_reg <= 1'b0;
            err_seq_reg   <= 1'b0;
            err_sym_reg   <= 1'b0;
            if (lp_accept) begin
                lp_state_reg <= lp_raw;
            end
            case (state_reg)
                ST_STOP: begin
                    if (lp_accept && lp_raw == 3'b001) begin
                        state_reg      <= ST_HS_RQST;
                        stop_state_reg <= 1'b0;
                    end
                end
                ST_HS_RQST: begin
                    if (lp_accept) begin
                        if (lp_raw == 3'b000) begin
                            state_reg    <= ST_HS_PREP;
                            prep_cnt_reg <= '0;
                        end else begin
                            // 111 is a clean return; anything else is illegal
                            err_seq_reg    <= (lp_raw != 3'b111);
                            state_reg      <= ST_STOP;
                            stop_state_reg <= 1'b1;
                        end
                    end
                end
                ST_HS_PREP: begin
                    if (lp_accept && lp_raw == 3'b111) begin
                        state_reg      <= ST_STOP;
                        stop_state_reg <= 1'b1;
                    end else if (ws_valid) begin
                        // First valid wire state only seeds the reference
                        prev_pair_reg <= ws_pair;
                        prev_pos_reg  <= ws_pos;
                        state_reg     <= ST_HS_RX;
                        hs_active_reg <= 1'b1;
                    end else if (prep_cnt_reg == PREP_LIMIT) begin
                        err_seq_reg    <= 1'b1;
                        state_reg      <= ST_STOP;
                        stop_state_reg <= 1'b1;
                    end else begin
                        prep_cnt_reg <= prep_cnt_reg + PW'(1);
                    end
                end
                ST_HS_RX: begin
                    if (lp_accept && lp_raw == 3'b111) begin
                        state_reg      <= ST_STOP;
                        stop_state_reg <= 1'b1;
                        hs_active_reg  <= 1'b0;
                    end else if (ws_valid && !same_state) begin
                        sym_out_reg   <= sym;
                        sym_valid_reg <= 1'b1;
                        prev_pair_reg <= ws_pair;
                        prev_pos_reg  <= ws_pos;
                    end else if (lp_raw != 3'b111) begin
                        // Repeated or malformed state; LP-111 is the exit path, not an error
                        err_sym_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg      <= ST_STOP;
                    stop_state_reg <= 1'b1;
                    hs_active_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign LpState   = lp_state_reg;
    assign StopState = stop_state_reg;
    assign HsActive  = hs_active_reg;
    assign SymOut    = sym_out_reg;
    assign SymValid  = sym_valid_reg;
    assign ErrSeq    = err_seq_reg;
    assign ErrSym    = err_sym_reg;

endmodule

// File: tb/tb_slave_line_receiver.sv
// Directed bench for slave_line_receiver: expected symbols are queued as
// wire states are driven and checked when the DUT reports them.
module tb_slave_line_receiver;
    logic       clk;
    logic       rst_n;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] C;
    logic       RxEn;
    logic [2:0] LpState;
    logic       StopState;
    logic       HsActive;
    logic [2:0] SymOut;
    logic       SymValid;
    logic       ErrSeq;
    logic       ErrSym;

    slave_line_receiver #(.LP_FILTER(2), .HS_PREP_MAX(15)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .C         (C),
        .RxEn      (RxEn),
        .LpState   (LpState),
        .StopState (StopState),
        .HsActive  (HsActive),
        .SymOut    (SymOut),
        .SymValid  (SymValid),
        .ErrSeq    (ErrSeq),
        .ErrSym    (ErrSym)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wire states: 0:+x 1:-x 2:+y 3:-y 4:+z 5:-z (even index = positive)
    logic [7:0] tab_a [6] = '{8'd40, 8'd0,  8'd20, 8'd20, 8'd0,  8'd40};
    logic [7:0] tab_b [6] = '{8'd0,  8'd40, 8'd40, 8'd0,  8'd20, 8'd20};
    logic [7:0] tab_c [6] = '{8'd20, 8'd20, 8'd0,  8'd40, 8'd40, 8'd0};

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [2:0] sb [$];
    logic [2:0] last_exp_sym = 3'b000;
    int         model_prev = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] sym_model(input int p, input int c);
        int pp;
        int cp;
        bit pneg;
        bit cneg;
        pp   = p / 2;
        cp   = c / 2;
        pneg = (p % 2) == 1;
        cneg = (c % 2) == 1;
        if (pp == cp) return 3'b100;
        return {1'b0, (((cp - pp + 3) % 3) == 1), (pneg != cneg)};
    endfunction

    // One clock of stimulus followed by the per-cycle output checks
    task automatic tick(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input bit exp_sym_err, input bit exp_seq_err, input string tag);
        bit exp_v;
        A = a;
        B = b;
        C = c;
        @(posedge clk);
        #1;
        exp_v = (sb.size() > 0);
        if (exp_v) last_exp_sym = sb.pop_front();
        chk({tag, ":SymValid"}, 32'(SymValid), 32'(exp_v));
        chk({tag, ":SymOut"}, 32'(SymOut), 32'(last_exp_sym));
        chk({tag, ":ErrSym"}, 32'(ErrSym), 32'(exp_sym_err));
        chk({tag, ":ErrSeq"}, 32'(ErrSeq), 32'(exp_seq_err));
        $display("cycle %s A=%0d B=%0d C=%0d -> Lp=%0b Stop=%0b Hs=%0b Sym=%0b V=%0b ESeq=%0b ESym=%0b",
                 tag, a, b, c, LpState, StopState, HsActive, SymOut, SymValid, ErrSeq, ErrSym);
    endtask

    task automatic lp(input logic [2:0] code, input int n, input int seq_at, input string tag);
        for (int i = 1; i <= n; i++) begin
            tick(code[2] ? 8'd100 : 8'd0, code[1] ? 8'd100 : 8'd0, code[0] ? 8'd100 : 8'd0,
                 1'b0, (i == seq_at), tag);
        end
    endtask

    // HS wire state while in HS_RX: queue the symbol or expect a repeat error
    task automatic hs(input int idx, input string tag);
        bit err;
        err = (idx == model_prev);
        if (!err) begin
            sb.push_back(sym_model(model_prev, idx));
            model_prev = idx;
        end
        tick(tab_a[idx], tab_b[idx], tab_c[idx], err, 1'b0, tag);
    endtask

    task automatic check_state(input logic stop, input logic hsa, input logic [2:0] lps,
                               input string tag);
        chk({tag, ":StopState"}, 32'(StopState), 32'(stop));
        chk({tag, ":HsActive"}, 32'(HsActive), 32'(hsa));
        chk({tag, ":LpState"}, 32'(LpState), 32'(lps));
    endtask

    task automatic enter_rx(input string tag);
        lp(3'b111, 2, 0, tag);
        lp(3'b001, 2, 0, tag);
        lp(3'b000, 2, 0, tag);
        tick(tab_a[0], tab_b[0], tab_c[0], 1'b0, 1'b0, tag);
        model_prev = 0;
        check_state(1'b0, 1'b1, 3'b000, tag);
    endtask

    initial begin
        rst_n = 1'b0;
        RxEn  = 1'b1;
        A = 8'd255;
        B = 8'd255;
        C = 8'd255;
        repeat (2) @(posedge clk);
        #1;
        check_state(1'b1, 1'b0, 3'b000, "reset");
        chk("reset:SymOut", 32'(SymOut), 32'd0);
        chk("reset:SymValid", 32'(SymValid), 32'd0);
        chk("reset:ErrSeq", 32'(ErrSeq), 32'd0);
        chk("reset:ErrSym", 32'(ErrSym), 32'd0);
        rst_n = 1'b1;

        // Legal entry with three samples of each LP code
        lp(3'b111, 3, 0, "entry111");
        check_state(1'b1, 1'b0, 3'b111, "entry111");
        lp(3'b001, 3, 0, "entry001");
        check_state(1'b0, 1'b0, 3'b001, "entry001");
        lp(3'b000, 3, 0, "entry000");
        check_state(1'b0, 1'b0, 3'b000, "entry000");
        tick(tab_a[0], tab_b[0], tab_c[0], 1'b0, 1'b0, "entry+x");
        model_prev = 0;
        check_state(1'b0, 1'b1, 3'b000, "entry+x");

        // Decode: covers 010, 100, 001, 011, 000
        hs(2, "+y");
        hs(3, "-y");
        hs(5, "-z");
        hs(1, "-x");
        hs(4, "+z");
        hs(1, "-x2");
        hs(5, "-z2");

        // Errors in HS_RX
        hs(2, "+y3");
        hs(2, "+y_rep");
        tick(8'd255, 8'd255, 8'd255, 1'b1, 1'b0, "hiz");
        hs(3, "-y_after");
        check_state(1'b0, 1'b1, 3'b000, "rx_err");

        // LP-111 exit without ErrSym
        lp(3'b111, 2, 0, "exit111");
        check_state(1'b1, 1'b0, 3'b111, "exit111");

        // Threshold boundary: 255 and 69 are LP low, 70 is LP high -> code 001
        tick(8'd255, 8'd69, 8'd70, 1'b0, 1'b0, "thr");
        tick(8'd255, 8'd69, 8'd70, 1'b0, 1'b0, "thr");
        check_state(1'b0, 1'b0, 3'b001, "thr");
        lp(3'b101, 2, 2, "illegal101");
        check_state(1'b1, 1'b0, 3'b101, "illegal101");

        // Single-cycle LP-000 glitch in HS_RQST must not be accepted
        lp(3'b111, 2, 0, "gl111");
        lp(3'b001, 2, 0, "gl001");
        lp(3'b000, 1, 0, "glitch");
        check_state(1'b0, 1'b0, 3'b001, "glitch");
        lp(3'b111, 2, 0, "gl_back");
        check_state(1'b1, 1'b0, 3'b111, "gl_back");

        // HS_PREP timeout
        lp(3'b001, 2, 0, "to001");
        lp(3'b000, 2, 0, "to000");
        for (int k = 1; k <= 16; k++) begin
            tick(8'd255, 8'd255, 8'd255, 1'b0, (k == 16), "prep_wait");
            if (k == 15) check_state(1'b0, 1'b0, 3'b000, "prep_k15");
        end
        check_state(1'b1, 1'b0, 3'b000, "timeout");

        // Reset mid-burst
        enter_rx("rx2");
        hs(1, "rx2-x");
        rst_n = 1'b0;
        last_exp_sym = 3'b000;
        tick(tab_a[3], tab_b[3], tab_c[3], 1'b0, 1'b0, "rst_mid");
        check_state(1'b1, 1'b0, 3'b000, "rst_mid");
        rst_n = 1'b1;

        // RxEn=0 mid-burst, then filter restarts from zero
        enter_rx("rx3");
        hs(2, "rx3+y");
        RxEn = 1'b0;
        last_exp_sym = 3'b000;
        tick(tab_a[4], tab_b[4], tab_c[4], 1'b0, 1'b0, "rxen_off");
        check_state(1'b1, 1'b0, 3'b000, "rxen_off");
        RxEn = 1'b1;
        lp(3'b111, 1, 0, "refilter1");
        check_state(1'b1, 1'b0, 3'b000, "refilter1");
        lp(3'b111, 1, 0, "refilter2");
        check_state(1'b1, 1'b0, 3'b111, "refilter2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
